// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_tx_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Width of an index into n requesters, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester and serialiser channels of the UART transmit arbiter.
interface uart_tx_arb_if
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) ();

    localparam int IW = idx_w(N_REQ);

    logic [N_REQ-1:0]        i_req_valid;
    logic [N_REQ*DATA_W-1:0] i_req_data;
    logic [N_REQ-1:0]        i_req_last;
    logic [N_REQ-1:0]        o_req_ready;
    logic                    o_tx_valid;
    logic [DATA_W-1:0]       o_tx_data;
    logic                    i_tx_ready;
    logic [N_REQ-1:0]        o_grant;
    logic                    o_busy;
    logic                    o_timeout;
    logic [IW-1:0]           o_timeout_id;

    modport master (
        input  i_req_valid, i_req_data, i_req_last, i_tx_ready,
        output o_req_ready, o_tx_valid, o_tx_data, o_grant, o_busy,
               o_timeout, o_timeout_id
    );

    modport slave (
        output i_req_valid, i_req_data, i_req_last, i_tx_ready,
        input  o_req_ready, o_tx_valid, o_tx_data, o_grant, o_busy,
               o_timeout, o_timeout_id
    );

endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping.
module uart_tx_arb_rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]          req,
    input  logic [idx_w(N_REQ)-1:0]   ptr,
    output logic [N_REQ-1:0]          gnt,
    output logic [idx_w(N_REQ)-1:0]   idx
);

    int k;

    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        gnt = '0;
        idx = '0;
        k   = 0;
        // Scan farthest first so the nearest candidate overwrites and wins.
        for (int i = N_REQ; i >= 1; i--) begin
            k = (int'(ptr) + i) % N_REQ;
            if (req[k]) begin
                gnt = N_REQ'(1) << k;
                idx = idx_w(N_REQ)'(k);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART byte transmitter between N_REQ packet sources,
// with grant locking per packet and an idle timeout that revokes a stalled grant.
module uart_tx_arb
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic          i_clk,
    input  logic          i_rst,
    uart_tx_arb_if.master bus
);

    localparam int IW = idx_w(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e        state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     gnt_idx;
    logic [CW-1:0]     idle_cnt;
    logic [N_REQ-1:0]  pick_gnt;
    logic [IW-1:0]     pick_idx;

    logic              out_free;
    logic              g_valid;
    logic              g_last;
    logic [DATA_W-1:0] g_data;
    logic              accept;
    logic              cnt_en;
    logic              to_hit;
    logic              release_now;

    uart_tx_arb_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req (bus.i_req_valid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    always_comb begin
        out_free = !bus.o_tx_valid || bus.i_tx_ready;
        g_valid  = bus.i_req_valid[gnt_idx];
        g_last   = bus.i_req_last[gnt_idx];
        g_data   = bus.i_req_data[gnt_idx*DATA_W +: DATA_W];
        accept   = (state == LOCK) && out_free && g_valid;
        // Only cycles where the owner could have sent but did not count as idle.
        cnt_en   = (state == LOCK) && out_free && !g_valid;
        to_hit   = cnt_en && (idle_cnt == CW'(TIMEOUT - 1));
        release_now      = (accept && g_last) || to_hit;
        bus.o_req_ready  = ((state == LOCK) && out_free) ? bus.o_grant : '0;
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, whatever the statement order below.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= IDLE;
            ptr              <= IW'(N_REQ - 1);
            gnt_idx          <= '0;
            idle_cnt         <= '0;
            bus.o_grant      <= '0;
            bus.o_busy       <= 1'b0;
            bus.o_tx_valid   <= 1'b0;
            bus.o_tx_data    <= '0;
            bus.o_timeout    <= 1'b0;
            bus.o_timeout_id <= '0;
        end else begin
            bus.o_timeout <= 1'b0;

            if (accept) begin
                bus.o_tx_valid <= 1'b1;
                bus.o_tx_data  <= g_data;
            end else if (bus.i_tx_ready) begin
                bus.o_tx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|bus.i_req_valid) begin
                        state       <= LOCK;
                        bus.o_grant <= pick_gnt;
                        bus.o_busy  <= 1'b1;
                        gnt_idx     <= pick_idx;
                    end
                end
                LOCK: begin
                    if (accept)      idle_cnt <= '0;
                    else if (cnt_en) idle_cnt <= idle_cnt + 1'b1;

                    if (to_hit) begin
                        bus.o_timeout    <= 1'b1;
                        bus.o_timeout_id <= gnt_idx;
                    end
                    if (release_now) begin
                        state       <= IDLE;
                        bus.o_grant <= '0;
                        bus.o_busy  <= 1'b0;
                        ptr         <= gnt_idx;
                        idle_cnt    <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: arbitration order, handshake, stall, timeout and reset.
module tb_uart_tx_arb;

    logic clk;
    logic rst;

    uart_tx_arb_if #(.N_REQ(4), .DATA_W(8)) bus ();

    uart_tx_arb #(.N_REQ(4), .DATA_W(8), .TIMEOUT(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // Requester model: requester k sends len[k] bytes valued k*16+pos+1.
    int         len [4];
    int         pos [4];
    logic [7:0] last_map [4];
    logic [3:0] hold;

    logic [7:0] tx_q [$];
    logic [3:0] gnt_q [$];
    int         acc_cyc [$];
    logic [7:0] exp_b [$];
    logic [3:0] exp_g [$];
    logic [3:0] fire;
    logic [3:0] prev_grant;
    int         cyc;
    int         to_cnt;
    int         to_cyc;
    int         t0;
    logic [7:0] held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        for (int k = 0; k < 4; k++) begin
            bus.i_req_valid[k]       = !hold[k] && (pos[k] < len[k]);
            bus.i_req_data[k*8 +: 8] = 8'(k * 16 + pos[k] + 1);
            bus.i_req_last[k]        = (pos[k] < 8) ? last_map[k][pos[k]] : 1'b0;
        end
    endtask

    task automatic load(input int k, input int n, input logic [7:0] m);
        len[k]      = n;
        pos[k]      = 0;
        last_map[k] = m;
    endtask

    task automatic clear_all();
        for (int k = 0; k < 4; k++) load(k, 0, 8'h00);
        hold = 4'b0000;
        tx_q.delete();
        gnt_q.delete();
        acc_cyc.delete();
        to_cnt = 0;
        to_cyc = 0;
    endtask

    // One clock: observe at the falling edge, advance the requesters after the rising edge.
    task automatic tick();
        @(negedge clk);
        fire = bus.i_req_valid & bus.o_req_ready;
        if (bus.o_tx_valid && bus.i_tx_ready) tx_q.push_back(bus.o_tx_data);
        if (bus.o_grant != 4'b0 && prev_grant == 4'b0) gnt_q.push_back(bus.o_grant);
        prev_grant = bus.o_grant;
        if (bus.o_timeout) begin
            to_cnt++;
            to_cyc = cyc;
        end
        for (int k = 0; k < 4; k++) if (fire[k]) acc_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < 4; k++) if (fire[k]) pos[k]++;
        drive_reqs();
    endtask

    task automatic run_until_acc(input string tag, input int n, input int budget);
        int b = 0;
        while (acc_cyc.size() < n && b < budget) begin
            tick();
            b++;
        end
        check(tag, acc_cyc.size(), n);
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_nbytes"}, tx_q.size(), exp_b.size());
        for (int i = 0; i < exp_b.size(); i++)
            if (i < tx_q.size()) check($sformatf("%s_byte%0d", tag, i), tx_q[i], exp_b[i]);
    endtask

    task automatic check_grants(input string tag);
        check({tag, "_ngrants"}, gnt_q.size(), exp_g.size());
        for (int i = 0; i < exp_g.size(); i++)
            if (i < gnt_q.size()) check($sformatf("%s_grant%0d", tag, i), gnt_q[i], exp_g[i]);
    endtask

    initial begin
        cyc        = 0;
        prev_grant = 4'b0;
        rst        = 1'b1;
        bus.i_req_valid = '0;
        bus.i_req_data  = '0;
        bus.i_req_last  = '0;
        bus.i_tx_ready  = 1'b1;
        clear_all();
        drive_reqs();

        // Reset state
        tick();
        tick();
        check("rst_tx_valid",   bus.o_tx_valid,   0);
        check("rst_tx_data",    bus.o_tx_data,    0);
        check("rst_grant",      bus.o_grant,      0);
        check("rst_busy",       bus.o_busy,       0);
        check("rst_timeout",    bus.o_timeout,    0);
        check("rst_timeout_id", bus.o_timeout_id, 0);
        check("rst_req_ready",  bus.o_req_ready,  0);
        rst = 1'b0;

        // Requesters 1 and 3, three bytes each: 1 first, one idle cycle, then 3
        clear_all();
        load(1, 3, 8'b100);
        load(3, 3, 8'b100);
        drive_reqs();
        t0 = cyc;
        run_until_acc("t1_wait", 6, 30);
        repeat (2) tick();
        exp_b = '{8'h11, 8'h12, 8'h13, 8'h31, 8'h32, 8'h33};
        check_bytes("t1");
        exp_g = '{4'b0010, 4'b1000};
        check_grants("t1");
        if (acc_cyc.size() == 6) begin
            check("t1_acc0_cyc", acc_cyc[0] - t0, 1);
            check("t1_acc2_cyc", acc_cyc[2] - t0, 3);
            check("t1_acc3_cyc", acc_cyc[3] - t0, 5);
            check("t1_acc5_cyc", acc_cyc[5] - t0, 7);
        end

        // All four valid with single-byte packets; requester 0 has two of them
        clear_all();
        load(0, 2, 8'b11);
        load(1, 1, 8'b1);
        load(2, 1, 8'b1);
        load(3, 1, 8'b1);
        drive_reqs();
        run_until_acc("t2_wait", 5, 40);
        repeat (2) tick();
        exp_b = '{8'h01, 8'h11, 8'h21, 8'h31, 8'h02};
        check_bytes("t2");
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        check_grants("t2");

        // Serialiser stalls for five cycles mid-packet
        clear_all();
        load(1, 4, 8'b1000);
        drive_reqs();
        run_until_acc("t3_wait_a", 2, 20);
        bus.i_tx_ready = 1'b0;
        held = bus.o_tx_data;
        check("t3_held_value", held, 8'h12);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t3_stall%0d_data", i), bus.o_tx_data, 8'h12);
            check($sformatf("t3_stall%0d_valid", i), bus.o_tx_valid, 1);
            check($sformatf("t3_stall%0d_timeout", i), bus.o_timeout, 0);
        end
        check("t3_stall_ready", bus.o_req_ready, 0);
        bus.i_tx_ready = 1'b1;
        run_until_acc("t3_wait_b", 4, 20);
        repeat (2) tick();
        exp_b = '{8'h11, 8'h12, 8'h13, 8'h14};
        check_bytes("t3");
        check("t3_no_timeout", to_cnt, 0);

        // Requester 2 sends one byte without last, then goes silent
        clear_all();
        load(2, 1, 8'b0);
        load(0, 1, 8'b1);
        drive_reqs();
        begin
            int b = 0;
            while (to_cnt == 0 && b < 30) begin
                tick();
                b++;
            end
        end
        check("t4_timeout_seen", to_cnt, 1);
        if (acc_cyc.size() >= 1) check("t4_latency", to_cyc - acc_cyc[0], 9);
        check("t4_timeout_id", bus.o_timeout_id, 2);
        run_until_acc("t4_wait", 2, 20);
        repeat (2) tick();
        exp_b = '{8'h21, 8'h01};
        check_bytes("t4");
        exp_g = '{4'b0100, 4'b0001};
        check_grants("t4");
        check("t4_single_pulse", to_cnt, 1);
        check("t4_id_held", bus.o_timeout_id, 2);

        // Last byte accepted exactly when the idle count would reach the limit
        clear_all();
        load(3, 2, 8'b10);
        drive_reqs();
        run_until_acc("t5_wait", 1, 20);
        hold = 4'b1000;
        drive_reqs();
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("t5_idle%0d_timeout", i), bus.o_timeout, 0);
        end
        hold = 4'b0000;
        drive_reqs();
        tick();
        check("t5_accepted", acc_cyc.size(), 2);
        check("t5_timeout", bus.o_timeout, 0);
        check("t5_released", bus.o_busy, 0);
        repeat (2) tick();
        exp_b = '{8'h31, 8'h32};
        check_bytes("t5");
        check("t5_no_pulse", to_cnt, 0);

        // Reset while a byte is held against a stalled serialiser
        clear_all();
        load(1, 2, 8'b10);
        drive_reqs();
        run_until_acc("t6_wait", 1, 20);
        bus.i_tx_ready = 1'b0;
        rst = 1'b1;
        tick();
        check("t6_tx_valid",   bus.o_tx_valid,   0);
        check("t6_tx_data",    bus.o_tx_data,    0);
        check("t6_grant",      bus.o_grant,      0);
        check("t6_busy",       bus.o_busy,       0);
        check("t6_timeout",    bus.o_timeout,    0);
        check("t6_timeout_id", bus.o_timeout_id, 0);
        check("t6_req_ready",  bus.o_req_ready,  0);
        rst = 1'b0;
        bus.i_tx_ready = 1'b1;
        clear_all();
        load(0, 1, 8'b1);
        load(1, 1, 8'b1);
        drive_reqs();
        run_until_acc("t6_wait_b", 2, 20);
        repeat (2) tick();
        exp_g = '{4'b0001, 4'b0010};
        check_grants("t6");
        exp_b = '{8'h01, 8'h11};
        check_bytes("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
